// File: rtl/pid_incremental_if.sv
// Error-stage to PID handshake bundle.
// The error stage drives the sample; PID returns the command and status.
interface pid_incremental_if #(
  parameter int ancho = 19
);
  logic                    ListoERROR;
  logic signed [ancho-1:0] Error;
  logic signed [ancho-1:0] U;
  logic                    ListoPID;
  logic                    Busy;

  modport master (
    output ListoERROR, Error,
    input  U, ListoPID, Busy
  );

  modport slave (
    input  ListoERROR, Error,
    output U, ListoPID, Busy
  );
endinterface

// File: rtl/pid_incremental.sv
// Incremental PID: u(k) = sat(u(k-1) + (A0 e0 + A1 e1 + A2 e2) >>> FRAC).
// One shared multiplier, five-state sequence per accepted sample.
module pid_incremental #(
  parameter int ancho = 19,
  parameter int FRAC  = 8,
  parameter int A0    = 256,
  parameter int A1    = -128,
  parameter int A2    = 0,
  parameter int UMAX  = 255,
  parameter int UMIN  = -255
) (
  input  logic             clk,
  input  logic             reset,
  pid_incremental_if.slave bus
);
  localparam int MW = 2 * ancho;
  localparam int AW = MW + 2;

  localparam logic signed [ancho-1:0] C0 = ancho'(A0);
  localparam logic signed [ancho-1:0] C1 = ancho'(A1);
  localparam logic signed [ancho-1:0] C2 = ancho'(A2);
  localparam logic signed [ancho-1:0] UH = ancho'(UMAX);
  localparam logic signed [ancho-1:0] UL = ancho'(UMIN);
  localparam logic signed [AW-1:0]    HI = AW'(UMAX);
  localparam logic signed [AW-1:0]    LO = AW'(UMIN);

  typedef enum logic [2:0] {
    IDLE, MAC0, MAC1, MAC2, SAT
  } state_t;

  state_t                  state;
  logic                    lerr_d;
  logic signed [ancho-1:0] e0, e1, e2;
  logic signed [ancho-1:0] u_prev;
  logic signed [ancho-1:0] mc, me;
  logic signed [ancho-1:0] u_sat;
  logic signed [MW-1:0]    prod;
  logic signed [AW-1:0]    acc;
  logic signed [AW-1:0]    prod_x;
  logic signed [AW-1:0]    u_new;
  logic                    accept;

  assign accept = (state == IDLE) && bus.ListoERROR && !lerr_d;

  always_comb begin
    mc = '0;
    me = '0;
    unique case (state)
      MAC0: begin mc = C0; me = e0; end
      MAC1: begin mc = C1; me = e1; end
      MAC2: begin mc = C2; me = e2; end
      default: ;
    endcase
  end

  assign prod   = MW'(mc) * MW'(me);
  assign prod_x = AW'(prod);
  // Wide sum so the clamp is the only limiting, never a wrap.
  assign u_new  = AW'(u_prev) + (acc >>> FRAC);

  always_comb begin
    u_sat = u_new[ancho-1:0];
    if (u_new > HI)
      u_sat = UH;
    else if (u_new < LO)
      u_sat = UL;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      lerr_d       <= 1'b0;
      e0           <= '0;
      e1           <= '0;
      e2           <= '0;
      u_prev       <= '0;
      acc          <= '0;
      bus.U        <= '0;
      bus.ListoPID <= 1'b0;
      bus.Busy     <= 1'b0;
    end else begin
      lerr_d       <= bus.ListoERROR;
      bus.ListoPID <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            e0       <= bus.Error;
            bus.Busy <= 1'b1;
            state    <= MAC0;
          end
        end
        MAC0: begin
          acc   <= prod_x;
          state <= MAC1;
        end
        MAC1: begin
          acc   <= acc + prod_x;
          state <= MAC2;
        end
        MAC2: begin
          acc   <= acc + prod_x;
          state <= SAT;
        end
        SAT: begin
          // Saturated value feeds back: anti-windup.
          bus.U        <= u_sat;
          u_prev       <= u_sat;
          e2           <= e1;
          e1           <= e0;
          bus.ListoPID <= 1'b1;
          bus.Busy     <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
